// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory hierarchy: word width, RAM8 geometry
// and the clear-sweep state encoding used by ram8_bank.
package hack_mem_pkg;
   localparam int WORD_W      = 16;
   localparam int RAM8_DEPTH  = 8;
   localparam int RAM8_ADDR_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_e;
endpackage

// File: rtl/register16.sv
// WIDTH-bit word register with load enable and synchronous active-low reset.
// One instance per word of the RAM8 bank.
module register16
   import hack_mem_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Hold the stored word unless this register is the one being loaded.
   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = d;
      end
   end

   // Word storage; reset zeroes the word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/ram8_bank.sv
// RAM8 level of the Hack memory: eight word registers with load steering,
// an address-selected read mux and a self-timed clear sweep that zeroes one
// word per cycle (words 0..7) while busy is high.
// Optional build macro RAM8_REGISTERED_READ_EN registers the read port
// (one cycle of read latency); without it the read is combinational.
module ram8_bank
   import hack_mem_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = RAM8_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       in,
   input  logic                   load,
   input  logic [RAM8_ADDR_W-1:0] address,
   input  logic                   clear,
   output logic [WIDTH-1:0]       out,
   output logic                   busy
);

   localparam logic [RAM8_ADDR_W-1:0] LAST_IDX = RAM8_ADDR_W'(DEPTH - 1);

   sweep_state_e           state_q, state_d;
   logic [RAM8_ADDR_W-1:0] idx_q, idx_d;
   logic                   busy_q, busy_d;

   logic [RAM8_ADDR_W-1:0] wr_sel;
   logic                   wr_en;
   logic [WIDTH-1:0]       wr_data;
   logic [DEPTH-1:0]       load_vec;
   logic [WIDTH-1:0]       word [DEPTH];
   logic [WIDTH-1:0]       rd_word;

   // Write port: the sweep owns the port while running, so host loads are dropped.
   always_comb begin
      wr_sel  = address;
      wr_en   = load;
      wr_data = in;
      if (state_q == SWEEP) begin
         wr_sel  = idx_q;
         wr_en   = 1'b1;
         wr_data = '0;
      end
   end

   // One-hot load steering: at most one word register changes per cycle.
   always_comb begin
      load_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         load_vec[i] = wr_en && (wr_sel == RAM8_ADDR_W'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      register16 #(
         .WIDTH (WIDTH)
      ) u_word (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load_vec[g]),
         .d     (wr_data),
         .q     (word[g])
      );
   end

   assign rd_word = word[address];

   // Sweep sequencing: start on clear in IDLE, walk idx 0..7, return to IDLE after word 7.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (clear) begin
               state_d = SWEEP;
               idx_d   = '0;
               busy_d  = 1'b1;
            end
         end
         SWEEP: begin
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
               idx_d   = '0;
               busy_d  = 1'b0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Sweep state, index and registered busy flag; reset aborts any sweep.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;

`ifdef RAM8_REGISTERED_READ_EN
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;

   // Next read value is the currently addressed word.
   always_comb begin
      out_d = rd_word;
   end

   // Registered read port; reset forces the output to zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;
`else
   assign out = rd_word;
`endif

endmodule

// File: tb/tb_ram8_bank.sv
// Self-checking bench for ram8_bank. A cycle model predicts the read data
// and busy flag at every edge; predictions are queued when stimulus is
// applied and popped for comparison 1 time unit after the edge.
// Works for both the default build and RAM8_REGISTERED_READ_EN.
module tb_ram8_bank;

   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic [2:0]  address;
   logic        clear;
   logic [15:0] out;
   logic        busy;

   ram8_bank dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in),
      .load    (load),
      .address (address),
      .clear   (clear),
      .out     (out),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] out_exp;
      logic        busy_exp;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem[8];
   logic        m_sweep;
   logic [2:0]  m_idx;
   int          vectors;
   int          miscompares;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance the reference model across one rising edge using current inputs.
   task automatic model_edge();
      exp_t        e;
      logic [15:0] pre_rd;
      pre_rd = mem[address];
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
         m_sweep = 1'b0;
         m_idx   = 3'd0;
         pre_rd  = 16'h0000;
      end else if (!m_sweep) begin
         if (load) mem[address] = in;
         if (clear) begin
            m_sweep = 1'b1;
            m_idx   = 3'd0;
         end
      end else begin
         mem[m_idx] = 16'h0000;
         if (m_idx == 3'd7) begin
            m_sweep = 1'b0;
            m_idx   = 3'd0;
         end else begin
            m_idx = m_idx + 3'd1;
         end
      end
`ifdef RAM8_REGISTERED_READ_EN
      e.out_exp = pre_rd;
`else
      e.out_exp = mem[address];
`endif
      e.busy_exp = m_sweep;
      sb.push_back(e);
   endtask

   task automatic step(input logic rn, input logic ld, input logic clr,
                       input logic [2:0] a, input logic [15:0] d);
      exp_t e;
      rst_n   = rn;
      load    = ld;
      clear   = clr;
      address = a;
      in      = d;
      @(posedge clk);
      model_edge();
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("out", {16'h0, out}, {16'h0, e.out_exp});
         check("busy", {31'h0, busy}, {31'h0, e.busy_exp});
      end
   endtask

   // Read a word with address held long enough for either read style.
   task automatic read_lit(input string tag, input logic [2:0] a, input logic [15:0] lit);
      step(1'b1, 1'b0, 1'b0, a, 16'h0);
`ifdef RAM8_REGISTERED_READ_EN
      step(1'b1, 1'b0, 1'b0, a, 16'h0);
`endif
      check(tag, {16'h0, out}, {16'h0, lit});
   endtask

   initial begin
      int busy_cnt;
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 8; i++) mem[i] = 16'hxxxx;
      m_sweep = 1'b0;
      m_idx   = 3'd0;
      rst_n = 1'b0; load = 1'b0; clear = 1'b0; address = 3'd0; in = 16'h0;

      // Reset then read
      step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_out", {16'h0, out}, 32'd0);
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 3'(k), 16'h0);

      // Write/readback 0x1111*k
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 3'(k), 16'(16'h1111 * k));
      for (int k = 0; k < 8; k++) read_lit("wr_rd", 3'(k), 16'(16'h1111 * k));

      // Load steering
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 3'(k), 16'hA5A5);
      step(1'b1, 1'b1, 1'b0, 3'd5, 16'hBEEF);
      for (int k = 0; k < 8; k++) read_lit("steer", 3'(k), (k == 5) ? 16'hBEEF : 16'hA5A5);

      // Clear sweep with dropped load and ignored re-clear
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 3'(k), 16'hFFFF);
      busy_cnt = 0;
      step(1'b1, 1'b0, 1'b1, 3'd7, 16'h0);
      if (busy) busy_cnt++;
      for (int i = 0; i < 10; i++) begin
         if (i == 3)      step(1'b1, 1'b1, 1'b0, 3'd0, 16'h1234);
         else if (i == 5) step(1'b1, 1'b0, 1'b1, 3'd7, 16'h0);
         else             step(1'b1, 1'b0, 1'b0, 3'd7, 16'h0);
         if (busy) busy_cnt++;
      end
      check("busy_len", busy_cnt, 32'd8);
      read_lit("swp_w0", 3'd0, 16'h0000);
      read_lit("swp_w7", 3'd7, 16'h0000);

      // Reset mid-sweep
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 3'(k), 16'(16'h0101 * k + 1));
      step(1'b1, 1'b0, 1'b1, 3'd6, 16'h0);
      step(1'b1, 1'b0, 1'b0, 3'd6, 16'h0);
      step(1'b1, 1'b0, 1'b0, 3'd6, 16'h0);
      step(1'b0, 1'b0, 1'b0, 3'd6, 16'h0);
      check("midrst_busy", {31'h0, busy}, 32'd0);
      step(1'b1, 1'b1, 1'b0, 3'd2, 16'h0042);
      read_lit("midrst_w2", 3'd2, 16'h0042);
      for (int k = 0; k < 8; k++) if (k != 2) read_lit("midrst_w", 3'(k), 16'h0000);

      // Simultaneous clear and load in IDLE
      step(1'b1, 1'b1, 1'b1, 3'd4, 16'h5555);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 3'd4, 16'h0);
      read_lit("clrld_w4", 3'd4, 16'h0000);

      // Read latency with address held
      step(1'b1, 1'b1, 1'b0, 3'd3, 16'hCAFE);
      step(1'b1, 1'b0, 1'b0, 3'd3, 16'h0);
      check("cafe", {16'h0, out}, 32'h0000CAFE);
      step(1'b0, 1'b0, 1'b0, 3'd3, 16'h0);
      check("rst_out2", {16'h0, out}, 32'd0);

      if (sb.size() != 0) check("sb_left", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
